// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states and elaboration-time helpers for the binary-to-BCD converter
package bcd_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction stage, adds 3 to a nibble that is 5 or more
module bcd_digit_adj (
   input  logic [3:0] i_d,
   output logic [3:0] o_d
);
   assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per clock, with handshake, ovf and blanking mask
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 6,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic [DIGITS-1:0]     lz_mask,
   output logic                  done
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = clog2(BIN_W + 1);
   localparam logic [63:0] OVF_TH = pow10(DIGITS);
   localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

   state_t             r_state;
   logic [BIN_W-1:0]   r_sh;
   logic [BW-1:0]      r_work;
   logic [BW-1:0]      r_bcd;
   logic [CW-1:0]      r_cnt;
   logic               r_ovf_pend;
   logic               r_ovf;
   logic               r_done;
   logic [DIGITS-1:0]  r_lz;
   logic [BW-1:0]      w_adj;
   logic [DIGITS-1:0]  w_lz;
   logic               w_z;
   logic               w_ovf_in;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_d (r_work[4*i +: 4]),
         .o_d (w_adj[4*i +: 4])
      );
   end

   assign w_ovf_in = 64'(bin) >= OVF_TH;

   // A digit is blanked only when it and every digit above it are zero; units never blank
   always_comb begin
      w_lz = '0;
      w_z  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_z     = w_z & (r_work[4*i +: 4] == 4'd0);
         w_lz[i] = w_z;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_sh       <= '0;
         r_work     <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_bcd      <= '0;
         r_ovf      <= 1'b0;
         r_lz       <= LZ_RST;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (in_valid) begin
               r_sh       <= bin;
               r_work     <= '0;
               r_cnt      <= CW'(BIN_W);
               r_ovf_pend <= w_ovf_in;
               r_state    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // The bit leaving the top digit is dropped, giving bin mod 10^DIGITS
               {r_work, r_sh} <= {w_adj, r_sh} << 1;
               r_cnt          <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_bcd   <= r_work;
               r_ovf   <= r_ovf_pend;
               r_lz    <= w_lz;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready = (r_state == ST_IDLE);
   assign bcd      = r_bcd;
   assign ovf      = r_ovf;
   assign lz_mask  = r_lz;
   assign done     = r_done;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of three converter configurations against an arithmetic model
module tb_bin2bcd_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tb_bin;
   logic        tb_valid;
   int          sel;
   int          checks = 0;
   int          failures = 0;

   logic [7:0]  a_bcd;
   logic [1:0]  a_lz;
   logic        a_ovf, a_done, a_ready;
   logic [3:0]  b_bcd;
   logic [0:0]  b_lz;
   logic        b_ovf, b_done, b_ready;
   logic [19:0] c_bcd;
   logic [4:0]  c_lz;
   logic        c_ovf, c_done, c_ready;

   logic [19:0] o_bcd;
   logic [4:0]  o_lz;
   logic        o_ovf, o_done, o_ready;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) u_a (
      .clk(clk), .rst(rst), .bin(tb_bin[5:0]), .in_valid(tb_valid && sel == 0),
      .in_ready(a_ready), .bcd(a_bcd), .ovf(a_ovf), .lz_mask(a_lz), .done(a_done));
   bin2bcd_seq #(.BIN_W(6), .DIGITS(1)) u_b (
      .clk(clk), .rst(rst), .bin(tb_bin[5:0]), .in_valid(tb_valid && sel == 1),
      .in_ready(b_ready), .bcd(b_bcd), .ovf(b_ovf), .lz_mask(b_lz), .done(b_done));
   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
      .clk(clk), .rst(rst), .bin(tb_bin), .in_valid(tb_valid && sel == 2),
      .in_ready(c_ready), .bcd(c_bcd), .ovf(c_ovf), .lz_mask(c_lz), .done(c_done));

   always_comb begin
      o_bcd   = sel == 0 ? 20'(a_bcd) : sel == 1 ? 20'(b_bcd) : c_bcd;
      o_lz    = sel == 0 ? 5'(a_lz) : sel == 1 ? 5'(b_lz) : c_lz;
      o_ovf   = sel == 0 ? a_ovf : sel == 1 ? b_ovf : c_ovf;
      o_done  = sel == 0 ? a_done : sel == 1 ? b_done : c_done;
      o_ready = sel == 0 ? a_ready : sel == 1 ? b_ready : c_ready;
   end

   function automatic int bw(input int s);
      return s == 2 ? 16 : 6;
   endfunction

   function automatic int dg(input int s);
      return s == 0 ? 2 : s == 1 ? 1 : 5;
   endfunction

   function automatic int p10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [19:0] m_bcd(input int v, input int d);
      logic [19:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic m_ovf(input int v, input int d);
      return v >= p10(d);
   endfunction

   function automatic logic [4:0] m_lz(input int v, input int d);
      logic [4:0] r;
      int m;
      r = '0;
      m = v % p10(d);
      for (int i = 1; i < d; i++) r[i] = (m < p10(i));
      return r;
   endfunction

   task automatic run_conv(input int v, output int lat, output bit ready_bad, output bit extra_done);
      int n;
      ready_bad  = 1'b0;
      extra_done = 1'b0;
      n = 0;
      while (!o_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      tb_bin   = 16'(v);
      tb_valid = 1'b1;
      @(posedge clk); #1;
      tb_valid = 1'b0;
      tb_bin   = 16'($urandom);
      lat = 0;
      if (o_ready || o_done) ready_bad = 1'b1;
      while (!o_done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (!o_done && o_ready) ready_bad = 1'b1;
      end
      if (o_done && !o_ready) ready_bad = 1'b1;
      @(posedge clk); #1;
      extra_done = o_done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tb_valid = 1'b0;
      tb_bin = '0;
      sel = 0;
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if (o_bcd !== 20'h0 || o_ovf !== 1'b0 || o_lz !== m_lz(0, dg(s)) || o_done !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset[%0d]: got bcd=%h ovf=%b lz=%b done=%b ready=%b expected bcd=0 ovf=0 lz=%b done=0 ready=1",
                     s, o_bcd, o_ovf, o_lz, o_done, o_ready, m_lz(0, dg(s)));
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_conv(input string name, input int lat, input int exp_lat, input bit ready_bad, input bit extra,
                             input logic [19:0] eb, input logic eo, input logic [4:0] el);
      checks++;
      if (lat != exp_lat || ready_bad || extra) begin
         failures++;
         $display("FAIL %s timing: got latency=%0d ready_bad=%0b extra_done=%0b expected latency=%0d ready_bad=0 extra_done=0",
                  name, lat, ready_bad, extra, exp_lat);
      end
      checks++;
      if (o_bcd !== eb || o_ovf !== eo || o_lz !== el) begin
         failures++;
         $display("FAIL %s result: got bcd=%h ovf=%b lz=%b expected bcd=%h ovf=%b lz=%b", name, o_bcd, o_ovf, o_lz, eb, eo, el);
      end
   endtask

   task automatic test_two_digit();
      int lat;
      bit rb, ex;
      sel = 0; #1;
      run_conv(59, lat, rb, ex);
      check_conv("d2_59", lat, 7, rb, ex, 20'h59, 1'b0, 5'b00000);
      run_conv(63, lat, rb, ex);
      check_conv("d2_63", lat, 7, rb, ex, 20'h63, 1'b0, 5'b00000);
      run_conv(0, lat, rb, ex);
      check_conv("d2_0", lat, 7, rb, ex, 20'h00, 1'b0, 5'b00010);
   endtask

   task automatic test_overflow();
      int lat;
      bit rb, ex;
      sel = 1; #1;
      run_conv(63, lat, rb, ex);
      check_conv("d1_63", lat, 7, rb, ex, 20'h3, 1'b1, 5'b00000);
      run_conv(9, lat, rb, ex);
      check_conv("d1_9", lat, 7, rb, ex, 20'h9, 1'b0, 5'b00000);
   endtask

   task automatic test_wide();
      int lat;
      bit rb, ex;
      sel = 2; #1;
      run_conv(65535, lat, rb, ex);
      check_conv("w16_65535", lat, 17, rb, ex, 20'h65535, 1'b0, 5'b00000);
      run_conv(7, lat, rb, ex);
      check_conv("w16_7", lat, 17, rb, ex, 20'h00007, 1'b0, 5'b11110);
   endtask

   task automatic test_random();
      int lat, v, mx, d;
      bit rb, ex;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         mx = (1 << bw(s)) - 1;
         d  = dg(s);
         for (int k = 0; k < 10; k++) begin
            v = k == 0 ? 0 : k == 1 ? mx : k == 2 ? (p10(d) - 1 > mx ? mx : p10(d) - 1)
              : k == 3 ? (p10(d) > mx ? mx : p10(d)) : int'($urandom_range(0, mx));
            run_conv(v, lat, rb, ex);
            check_conv($sformatf("rand_s%0d_v%0d", s, v), lat, bw(s) + 1, rb, ex, m_bcd(v, d), m_ovf(v, d), m_lz(v, d));
         end
      end
   endtask

   task automatic test_back_to_back();
      int q[$];
      int last_acc, n_acc, n_done, e;
      sel = 0; #1;
      last_acc = -1;
      n_acc = 0;
      n_done = 0;
      tb_valid = 1'b1;
      for (int k = 0; k < 80; k++) begin
         tb_bin = 16'($urandom_range(0, 63));
         if (k < 70 && o_ready) begin
            q.push_back(int'(tb_bin));
            if (last_acc >= 0) begin
               checks++;
               if (k - last_acc != 8) begin
                  failures++;
                  $display("FAIL b2b_gap: got %0d cycles between accepts expected 8", k - last_acc);
               end
            end
            last_acc = k;
            n_acc++;
         end
         if (k == 69) tb_valid = 1'b0;
         @(posedge clk); #1;
         if (o_done) begin
            n_done++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL b2b_done: got done with no accepted request expected none");
            end else begin
               e = q.pop_front();
               if (o_bcd !== m_bcd(e, 2) || o_ovf !== m_ovf(e, 2) || o_lz !== m_lz(e, 2)) begin
                  failures++;
                  $display("FAIL b2b_result: got bcd=%h ovf=%b lz=%b expected bcd=%h ovf=%b lz=%b for bin=%0d",
                           o_bcd, o_ovf, o_lz, m_bcd(e, 2), m_ovf(e, 2), m_lz(e, 2), e);
               end
            end
         end
      end
      tb_valid = 1'b0;
      checks++;
      if (n_acc < 8 || n_done != n_acc || q.size() != 0) begin
         failures++;
         $display("FAIL b2b_count: got accepts=%0d dones=%0d pending=%0d expected accepts>=8 dones=accepts pending=0",
                  n_acc, n_done, q.size());
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit rb, ex, saw;
      sel = 0; #1;
      run_conv(47, lat, rb, ex);
      check_conv("pre_rst_47", lat, 7, rb, ex, 20'h47, 1'b0, 5'b00000);
      tb_bin = 16'd45;
      tb_valid = 1'b1;
      @(posedge clk); #1;
      tb_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (o_bcd !== 20'h0 || o_ovf !== 1'b0 || o_lz !== 5'b00010 || o_done !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_rst: got bcd=%h ovf=%b lz=%b done=%b ready=%b expected bcd=0 ovf=0 lz=00010 done=0 ready=1",
                  o_bcd, o_ovf, o_lz, o_done, o_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      saw = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (o_done) saw = 1'b1;
      end
      checks++;
      if (saw) begin
         failures++;
         $display("FAIL mid_rst_nodone: got a done pulse after reset expected none");
      end
      run_conv(12, lat, rb, ex);
      check_conv("post_rst_12", lat, 7, rb, ex, 20'h12, 1'b0, 5'b00000);
   endtask

   initial begin
      test_reset();
      test_two_digit();
      test_overflow();
      test_wide();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "timeout");
   end
endmodule
